// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state encoding
// and requester identifiers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_D  = 2'd2,
        RESP     = 2'd3
    } state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/arb_prio2.sv
// Two-way priority pick: data beats fetch unless the fetch side has been
// starved long enough, in which case a waiting fetch wins.
module arb_prio2 (
    input  logic req_if_i,
    input  logic req_d_i,
    input  logic starve_i,
    output logic grant_valid_o,
    output logic grant_id_o
);
    import mem_arbiter_pkg::*;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        grant_valid_o = req_if_i | req_d_i;
        grant_id_o    = REQ_IF;
        if (req_d_i && !(req_if_i && starve_i)) begin
            grant_id_o = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access;
// one access outstanding at a time, with a starvation bound on fetch.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          if_stall,
    output logic          d_stall
);
    import mem_arbiter_pkg::*;

    localparam int            CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    state_e        state_q;
    logic [CW-1:0] starve_cnt_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          if_ready_q;
    logic          d_ready_q;
    logic          grant_valid;
    logic          grant_id;

    arb_prio2 u_prio (
        .req_if_i      (if_req),
        .req_d_i       (d_req),
        .starve_i      (starve_cnt_q == STARVE_LIM),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        mem_req_q <= 1'b1;
                        if (grant_id == REQ_D) begin
                            mem_addr_q  <= d_addr;
                            mem_we_q    <= d_we;
                            mem_wdata_q <= d_wdata;
                            state_q     <= GRANT_D;
                            if (if_req && starve_cnt_q != STARVE_LIM) begin
                                starve_cnt_q <= starve_cnt_q + 1'b1;
                            end
                        end else begin
                            mem_addr_q   <= if_addr;
                            mem_we_q     <= 1'b0;
                            state_q      <= GRANT_IF;
                            starve_cnt_q <= '0;
                        end
                    end
                end
                GRANT_IF: begin
                    if (mem_ack) begin
                        if_rdata_q <= mem_rdata;
                        if_ready_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= RESP;
                    end
                end
                GRANT_D: begin
                    if (mem_ack) begin
                        // Writes complete without touching the held read data.
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                        d_ready_q <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign if_stall  = if_req & ~if_ready_q;
    assign d_stall   = d_req & ~d_ready_q;

    // A requester must hold its request until its own ready pulse.
    a_if_req_held: assert property (@(posedge clk) disable iff (reset)
        (state_q == GRANT_IF || (state_q == RESP && if_ready_q)) |-> if_req);
    a_d_req_held: assert property (@(posedge clk) disable iff (reset)
        (state_q == GRANT_D || (state_q == RESP && d_ready_q)) |-> d_req);
    a_one_ready: assert property (@(posedge clk) !(if_ready_q && d_ready_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int AW         = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   if_rdata, d_rdata;
    logic          if_ready, d_ready;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack;
    logic          if_stall, d_stall;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .if_stall(if_stall), .d_stall(d_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle counter and the inputs as the DUT saw them at the latest edge.
    int            cyc = 0;
    logic          rst_s = 1'b1;
    logic          s_if_req = 1'b0, s_d_req = 1'b0, s_d_we = 1'b0;
    logic [AW-1:0] s_if_addr = '0, s_d_addr = '0;
    logic [31:0]   s_d_wdata = '0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rst_s     <= reset;
        s_if_req  <= if_req;
        s_d_req   <= d_req;
        s_d_we    <= d_we;
        s_if_addr <= if_addr;
        s_d_addr  <= d_addr;
        s_d_wdata <= d_wdata;
    end

    // Memory responder: acks ack_delay cycles after mem_req first rises.
    int          ack_delay  = 0;
    logic [31:0] rdata_base = '0;
    bit          force_ack  = 1'b0;

    initial begin
        int cnt;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
                force_ack = 1'b0;
                cnt       = 0;
            end else if (mem_req && !mem_ack) begin
                if (cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_base ^ mem_addr;
                    cnt       = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                cnt     = 0;
            end
        end
    end

    // Reference model: one outstanding access, grant one cycle after the
    // arbiter is free and a request is seen, ready the cycle after the ack.
    bit          busy = 1'b0, acked = 1'b0, own_d = 1'b0, e_we = 1'b0;
    int          free_cyc = 0, ack_cyc = 0, streak = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_rd = '0;
    logic [31:0] m_if_rdata = '0, m_d_rdata = '0;
    bit          grant_log[$];

    initial begin
        bit grant_exp;
        forever begin
            @(negedge clk);
            check("one_ready", 32'(if_ready & d_ready), 32'd0);
            check("if_stall", 32'(if_stall), 32'(if_req & ~if_ready));
            check("d_stall", 32'(d_stall), 32'(d_req & ~d_ready));
            if (rst_s) begin
                busy = 1'b0; streak = 0; free_cyc = cyc;
                m_if_rdata = '0; m_d_rdata = '0;
                check("rst_mem_req", 32'(mem_req), 32'd0);
                check("rst_mem_we", 32'(mem_we), 32'd0);
                check("rst_mem_addr", mem_addr, 32'd0);
                check("rst_mem_wdata", mem_wdata, 32'd0);
                check("rst_ready", 32'({if_ready, d_ready}), 32'd0);
            end else begin
                if (busy && acked && cyc == ack_cyc + 1) begin
                    check("ready_if", 32'(if_ready), 32'(!own_d));
                    check("ready_d", 32'(d_ready), 32'(own_d));
                    check("resp_mem_req", 32'(mem_req), 32'd0);
                    if (!own_d) m_if_rdata = e_rd;
                    else if (!e_we) m_d_rdata = e_rd;
                    busy = 1'b0;
                    free_cyc = cyc + 1;
                end else begin
                    check("no_ready", 32'({if_ready, d_ready}), 32'd0);
                end
                if (!busy) begin
                    grant_exp = (cyc - 1 >= free_cyc) && (s_if_req || s_d_req);
                    check("grant", 32'(mem_req), 32'(grant_exp));
                    if (grant_exp) begin
                        own_d = s_d_req && !(s_if_req && streak == STARVE_MAX);
                        if (own_d) begin
                            e_addr = s_d_addr; e_we = s_d_we; e_wdata = s_d_wdata;
                            if (s_if_req && streak < STARVE_MAX) streak++;
                        end else begin
                            e_addr = s_if_addr; e_we = 1'b0;
                            streak = 0;
                        end
                        grant_log.push_back(own_d);
                        busy = 1'b1; acked = 1'b0;
                    end
                end
                if (busy && !acked) begin
                    check("hold_mem_req", 32'(mem_req), 32'd1);
                    check("mem_addr", mem_addr, e_addr);
                    check("mem_we", 32'(mem_we), 32'(e_we));
                    if (own_d && e_we) check("mem_wdata", mem_wdata, e_wdata);
                    if (mem_ack) begin
                        acked = 1'b1; ack_cyc = cyc; e_rd = mem_rdata;
                    end
                end
            end
            check("if_rdata", if_rdata, m_if_rdata);
            check("d_rdata", d_rdata, m_d_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit data, input int budget, output int at);
        at = -1000;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((data ? d_ready : if_ready) === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_mem_req(input int budget, output int at);
        at = -1000;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int t, at, d_at, i_at;
        bit d_done, i_done;
        bit pattern [10];
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;

        // Reset state
        @(negedge clk);
        check("reset_if_rdata", if_rdata, 32'd0);
        check("reset_d_rdata", d_rdata, 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Lone fetch, ack 3 cycles after mem_req
        ack_delay = 3; rdata_base = 32'h1234_5678;
        if_addr = 32'h40; if_req = 1'b1; t = cyc;
        wait_mem_req(10, at);
        check("s040_grant_lat", 32'(at - t), 32'd1);
        check("s040_mem_addr", mem_addr, 32'h40);
        check("s040_mem_we", 32'(mem_we), 32'd0);
        wait_ready(1'b0, 20, at);
        check("s040_ready_lat", 32'(at - t), 32'd5);
        check("s040_if_rdata", if_rdata, 32'h1234_5638);
        tick(); if_req = 1'b0;
        repeat (2) tick();

        // Simultaneous fetch and data write: data first, then fetch
        ack_delay = 1; rdata_base = 32'hA5A5_0000;
        if_addr = 32'h44; if_req = 1'b1;
        d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'hCAFE_F00D; d_req = 1'b1;
        t = cyc; d_done = 1'b0; i_done = 1'b0; d_at = -1000; i_at = -1000;
        for (int i = 0; i < 30 && !(d_done && i_done); i++) begin
            @(negedge clk);
            if (d_ready === 1'b1 && !d_done) begin d_done = 1'b1; d_at = cyc; end
            if (if_ready === 1'b1 && !i_done) begin i_done = 1'b1; i_at = cyc; end
            tick();
            if (d_done) d_req = 1'b0;
            if (i_done) if_req = 1'b0;
        end
        check("s041_d_ready_lat", 32'(d_at - t), 32'd3);
        check("s041_if_ready_lat", 32'(i_at - t), 32'd7);
        check("s041_d_rdata_kept", d_rdata, 32'd0);
        check("s041_if_rdata", if_rdata, 32'hA5A5_0044);
        d_we = 1'b0;
        repeat (2) tick();

        // Ack in the first mem_req cycle: ready two cycles after the request
        ack_delay = 0; rdata_base = 32'h0F0F_0000;
        d_addr = 32'h200; d_req = 1'b1; t = cyc;
        wait_ready(1'b1, 10, at);
        check("s043_ready_lat", 32'(at - t), 32'd2);
        check("s043_d_rdata", d_rdata, 32'h0F0F_0200);
        tick(); d_req = 1'b0;
        repeat (2) tick();

        // Spurious ack while idle
        @(negedge clk); force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s045_no_ready", 32'({if_ready, d_ready}), 32'd0);
        end
        check("s045_if_rdata", if_rdata, 32'hA5A5_0044);
        check("s045_d_rdata", d_rdata, 32'h0F0F_0200);
        tick();

        // Both requests held: 4 data grants then 1 fetch, repeating
        ack_delay = 0; rdata_base = 32'h3C3C_0000;
        grant_log.delete();
        if_addr = 32'h80; d_addr = 32'h300; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 60 && grant_log.size() < 10; i++) @(negedge clk);
        pattern = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        check("s042_grant_count", 32'(grant_log.size() >= 10), 32'd1);
        for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
            check($sformatf("s042_grant_%0d", i), 32'(grant_log[i]), 32'(pattern[i]));
        end
        wait_ready(1'b0, 10, at);
        check("s042_if_ready_seen", 32'(at > 0), 32'd1);
        tick(); if_req = 1'b0;
        wait_ready(1'b1, 10, at);
        check("s042_d_ready_seen", 32'(at > 0), 32'd1);
        tick(); d_req = 1'b0;
        repeat (2) tick();

        // Reset while a data access is granted, stale ack right after
        ack_delay = 10; rdata_base = 32'h5555_0000;
        d_addr = 32'h180; d_we = 1'b0; d_req = 1'b1;
        wait_mem_req(10, at);
        check("s044_granted", 32'(at > 0), 32'd1);
        tick(); reset = 1'b1;
        @(negedge clk); force_ack = 1'b1;
        tick(); reset = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("s044_mem_req_low", 32'(mem_req), 32'd0);
        check("s044_stale_ack_present", 32'(mem_ack), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("s044_no_d_ready", 32'(d_ready), 32'd0);
        end
        check("s044_mem_addr", mem_addr, 32'd0);
        check("s044_d_rdata", d_rdata, 32'd0);
        check("s044_if_rdata", if_rdata, 32'd0);
        check("s044_mem_we", 32'(mem_we), 32'd0);
        tick();

        // Recovery after reset
        ack_delay = 2; rdata_base = 32'h7777_0000;
        if_addr = 32'h10; if_req = 1'b1; t = cyc;
        wait_ready(1'b0, 20, at);
        check("post_rst_lat", 32'(at - t), 32'd4);
        check("post_rst_if_rdata", if_rdata, 32'h7777_0010);
        tick(); if_req = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive data grants while a fetch request waits.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request; held high until if_ready.
REQ-006 if_addr  input  AW  fetch address; stable while if_req is high.
REQ-007 if_rdata  output  32  fetched word; valid when if_ready is high, held until the next if_ready.
REQ-008 if_ready  output  1  one-cycle completion pulse for a fetch.
REQ-009 d_req  input  1  data request; held high until d_ready.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  AW  data address; stable while d_req is high.
REQ-012 d_wdata  input  32  write data.
REQ-013 d_rdata  output  32  read data; valid when d_ready is high, held until the next d_ready.
REQ-014 d_ready  output  1  one-cycle completion pulse for a data access.
REQ-015 mem_req  output  1  request to the shared single-port memory.
REQ-016 mem_we  output  1  write strobe to memory.
REQ-017 mem_addr  output  AW  memory address.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_rdata  input  32  memory read data; valid when mem_ack is high.
REQ-020 mem_ack  input  1  memory completion; a one-cycle pulse, arriving in any cycle from the first cycle mem_req is high.
REQ-021 if_stall  output  1  high when if_req is high and if_ready is low; used by the pipeline to freeze IF.
REQ-022 d_stall  output  1  high when d_req is high and d_ready is low; used by the pipeline to freeze MEM and earlier stages.

Function
REQ-023 FSM states: IDLE, GRANT_IF, GRANT_D, RESP.
REQ-024 IDLE with a request pending: register the winner's address, we and wdata onto mem_* and go to GRANT_IF or GRANT_D; mem_req is high from the next cycle.
REQ-025 Priority: data wins over fetch, unless starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-026 starve_cnt: increments on each data grant made while if_req is high, saturating at STARVE_MAX; clears to 0 on each fetch grant.
REQ-027 GRANT_x: mem_req and mem_* stay constant until mem_ack; mem_we is 0 for fetch grants.
REQ-028 GRANT_x on mem_ack: capture mem_rdata into the owner's rdata register, drop mem_req, go to RESP.
REQ-029 RESP: assert the owner's ready for exactly one cycle, then return to IDLE.
REQ-030 In the RESP cycle the owner's req is ignored for arbitration, so a new request from that owner is considered from the following IDLE cycle.
REQ-031 Write access: d_rdata is left unchanged and d_ready still pulses.
REQ-032 Latency: req seen in IDLE at cycle t gives mem_req at t+1; mem_ack at t+1+k gives ready at t+2+k; minimum 2 cycles.
REQ-033 mem_ack while in IDLE or RESP is ignored and does not change any output.
REQ-034 A req that drops before ready is a protocol violation; behaviour is undefined and an assertion flags it.
REQ-035 At most one of if_ready, d_ready is high in any cycle; at most one access is outstanding.

Reset
REQ-036 Reset values: state IDLE; mem_req, mem_we, if_ready, d_ready, starve_cnt = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0.
REQ-037 Reset mid-transaction abandons the access; mem_req is low in the first cycle after the reset edge; a subsequent stale mem_ack is ignored per REQ-033.

Structure
REQ-038 A shared package holds the state enum and requester-ID constants (REQ_IF=0, REQ_D=1).
REQ-039 One sub-module, arb_prio2, is the combinational two-way priority pick with the starvation override.

Verification
REQ-040 Scenario: if_req only, addr 0x40, mem_ack 3 cycles after mem_req -> mem_addr=0x40, mem_we=0, if_ready 5 cycles after the request with if_rdata=mem_rdata.
REQ-041 Scenario: if_req and d_req rise in the same cycle, d_we=1, addr 0x100 -> data served first, d_ready pulses, d_rdata unchanged, then the fetch is served.
REQ-042 Scenario: d_req held continuously, if_req held, STARVE_MAX=4 -> exactly 4 data grants, then 1 fetch grant, then the pattern repeats.
REQ-043 Scenario: mem_ack in the same cycle mem_req first rises -> ready 2 cycles after the request.
REQ-044 Scenario: reset asserted in GRANT_D, then mem_ack one cycle later -> no d_ready, all outputs at their reset values.
REQ-045 Scenario: spurious mem_ack in IDLE -> no ready pulse, rdata unchanged.
